reg_access_arbiter: RTL and testbench
=====================================

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, cycles the arbiter waits in ACK for the winner to drop req before forced release; range 1..255.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  2  per-requester access request, bit n = requester n, four-phase.
REQ-005 wr_i  input  2  per-requester direction: 1 = write, 0 = read; sampled with req.
REQ-006 r0_addr_i / r1_addr_i  input  3 each  register address of requester 0 / 1.
REQ-007 r0_wdata_i / r1_wdata_i  input  16 each  write data of requester 0 / 1.
REQ-008 gnt_o  output  2  one-hot grant; bit n high from ACCESS through ACK for winner n.
REQ-009 ack_o  output  2  one-hot completion; bit n high in ACK until req_i[n] low.
REQ-010 r0_rdata_o / r1_rdata_o  output  16 each  last read data captured for requester 0 / 1.
REQ-011 acc_en_o, wr_en_o  output  1 each  register-block access strobe and direction.
REQ-012 addr_o  output  3; wdata_o  output  16  register-block address and write data.
REQ-013 rdata_i  input  16  register-block combinational read data, valid while acc_en_o=1, wr_en_o=0.
REQ-014 err_o  output  1  one-cycle pulse on ACK timeout (tied 0 when feature compiled out).

Function
REQ-015 FSM states IDLE, ACCESS, ACK; reset state IDLE.
REQ-016 IDLE: no req -> stay; any req -> pick winner, latch its wr/addr/wdata, go ACCESS next cycle.
REQ-017 Arbitration round-robin: single request wins; both requesting -> the requester not granted last wins; last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-018 ACCESS lasts exactly one cycle: acc_en_o=1, wr_en_o/addr_o/wdata_o = latched values; then ACK.
REQ-019 Read in ACCESS: rdata_i registered into winner's rdata output at end of ACCESS; other requester's rdata and all rdata on writes unchanged.
REQ-020 Outside ACCESS: acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0 (no spurious read or command pulse).
REQ-021 ACK: ack_o[winner]=1, gnt held; winner req_i low -> IDLE next cycle, ack and gnt drop; pointer updates to winner.
REQ-022 Latency: req rises in IDLE at cycle N -> acc_en_o at N+1 -> ack_o at N+2, rdata valid at N+2.
REQ-023 Loser's req held during another access is served on the IDLE cycle following ACK exit; no request is dropped.
REQ-024 Changes of winner's wr/addr/wdata after grant are ignored; req dropping before ACK has no effect on the access.
REQ-025 A write to address 5 therefore yields exactly one acc_en_o cycle per handshake.

Reset
REQ-026 rstn_i low at any time, including mid-ACCESS: state IDLE, pointer 1, gnt_o=0, ack_o=0, acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0, rdata outputs 0, err_o=0, timeout counter 0; interrupted access not completed.

Configuration
REQ-027 Macro REG_ARB_ACK_TIMEOUT_EN defined: 8-bit counter runs in ACK; after ACK_TIMEOUT cycles with winner req still high, FSM -> IDLE, err_o pulses 1 cycle, requester must drop req before being re-served (req must be seen low once).
REQ-028 Macro undefined: no counter, ACK waits indefinitely, err_o constant 0.

Structure
REQ-029 Shared package reg_arb_pkg: state enum, register address constants (CTRL0=0, PWM_MODE=1, CNT_MODE0=2, CNT_MODE1=3, ACT_CNT=4, CMD=5, CAPT=6), data width 16, address width 3.
REQ-030 One sub-module rr_arb2: combinational 2-way round-robin pick from req vector and last-grant pointer.

Verification
REQ-031 Reset; req_i=01, wr=1, addr=1, wdata=16'h3155 -> acc_en_o one cycle at N+1 with addr_o=1, wdata_o=3155; ack_o=01 at N+2.
REQ-032 rdata_i=16'h0203 during req1 read of addr 3 -> r1_rdata_o=0203 at N+2, r0_rdata_o unchanged.
REQ-033 Both req at reset -> grant order 0,1,0,1 over four back-to-back handshakes, one ACCESS each.
REQ-034 Write addr 5 wdata=16'h0011, req held 10 cycles in ACK -> exactly one acc_en_o cycle total.
REQ-035 rstn_i low during ACCESS -> all outputs 0 next sample, FSM IDLE, no ack issued.
REQ-036 With REG_ARB_ACK_TIMEOUT_EN, ACK_TIMEOUT=4, req held -> err_o pulse after 4 ACK cycles, FSM IDLE, no re-service until req drops.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the register-access arbiter.
package reg_arb_pkg;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [AW-1:0] CTRL0     = 3'd0;
    localparam logic [AW-1:0] PWM_MODE  = 3'd1;
    localparam logic [AW-1:0] CNT_MODE0 = 3'd2;
    localparam logic [AW-1:0] CNT_MODE1 = 3'd3;
    localparam logic [AW-1:0] ACT_CNT   = 3'd4;
    localparam logic [AW-1:0] CMD       = 3'd5;
    localparam logic [AW-1:0] CAPT      = 3'd6;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       win
);
    assign any = |req;
    assign win = &req ? ~last : req[1];
endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: two-requester four-phase arbiter in front of a register block.
// Optional ACK timeout with forced release is built when REG_ARB_ACK_TIMEOUT_EN is defined.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [1:0]    req_i,
    input  logic [1:0]    wr_i,
    input  logic [AW-1:0] r0_addr_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [DW-1:0] r0_wdata_i,
    input  logic [DW-1:0] r1_wdata_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    ack_o,
    output logic [DW-1:0] r0_rdata_o,
    output logic [DW-1:0] r1_rdata_o,
    output logic          acc_en_o,
    output logic          wr_en_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    input  logic [DW-1:0] rdata_i,
    output logic          err_o
);
    state_t        state, state_n;
    logic          last, win, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata0, rdata1;
    logic [1:0]    elig;
    logic          pick_any, pick_win, tmo, done;

    rr_arb2 u_arb (.req(elig), .last(last), .any(pick_any), .win(pick_win));

`ifdef REG_ARB_ACK_TIMEOUT_EN
    logic [7:0] cnt;
    logic [1:0] blocked;
    logic       err;
    // a timed-out requester stays blocked until its req has been seen low once
    assign tmo   = state == ACK && req_i[win] && cnt == 8'(ACK_TIMEOUT - 1);
    assign elig  = req_i & ~blocked;
    assign err_o = err;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= '0;
            blocked <= '0;
            err     <= 1'b0;
        end else begin
            cnt     <= (state == ACK && !tmo) ? cnt + 8'd1 : 8'd0;
            blocked <= (blocked & req_i) | (tmo ? onehot(win) : 2'b00);
            err     <= tmo;
        end
    end
`else
    assign tmo   = 1'b0;
    assign elig  = req_i;
    // ACK_TIMEOUT is never 0 in its legal range, so err_o is a constant 0
    assign err_o = ACK_TIMEOUT == 0;
`endif

    assign done       = state == ACK && (!req_i[win] || tmo);
    assign r0_rdata_o = rdata0;
    assign r1_rdata_o = rdata1;

    always_comb begin
        state_n  = state;
        gnt_o    = '0;
        ack_o    = '0;
        acc_en_o = 1'b0;
        wr_en_o  = 1'b0;
        addr_o   = '0;
        wdata_o  = '0;
        case (state)
            IDLE: state_n = pick_any ? ACCESS : IDLE;
            ACCESS: begin
                state_n  = ACK;
                gnt_o    = onehot(win);
                acc_en_o = 1'b1;
                wr_en_o  = wr;
                addr_o   = addr;
                wdata_o  = wdata;
            end
            ACK: begin
                state_n = done ? IDLE : ACK;
                gnt_o   = onehot(win);
                ack_o   = onehot(win);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            last   <= 1'b1;
            win    <= 1'b0;
            wr     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && pick_any) begin
                win   <= pick_win;
                wr    <= wr_i[pick_win];
                addr  <= pick_win ? r1_addr_i : r0_addr_i;
                wdata <= pick_win ? r1_wdata_i : r0_wdata_i;
            end
            if (state == ACCESS && !wr && !win) rdata0 <= rdata_i;
            if (state == ACCESS && !wr && win) rdata1 <= rdata_i;
            if (done) last <= win;
        end
    end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: directed handshakes plus randomized two-requester traffic
// checked against a transaction-level register model.
module tb_reg_access_arbiter;
    localparam int NTX = 25;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  rq = '0, wr = '0;
    logic [2:0]  ad [2];
    logic [15:0] wd [2];
    logic [1:0]  gnt, ack;
    logic [15:0] r0d, r1d, wdata, rdata;
    logic        acc_en, wr_en, err;
    logic [2:0]  addr;
    logic [15:0] regs [8];

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    reg_access_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(rq), .wr_i(wr),
        .r0_addr_i(ad[0]), .r1_addr_i(ad[1]), .r0_wdata_i(wd[0]), .r1_wdata_i(wd[1]),
        .gnt_o(gnt), .ack_o(ack), .r0_rdata_o(r0d), .r1_rdata_o(r1d),
        .acc_en_o(acc_en), .wr_en_o(wr_en), .addr_o(addr), .wdata_o(wdata),
        .rdata_i(rdata), .err_o(err)
    );

    // register block the arbiter fronts
    assign rdata = (acc_en && !wr_en) ? regs[addr] : 16'h0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) for (int i = 0; i < 8; i++) regs[i] <= '0;
        else if (acc_en && wr_en) regs[addr] <= wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string p);
        check({p, "_gnt"}, 32'(gnt), 0);
        check({p, "_ack"}, 32'(ack), 0);
        check({p, "_acc"}, 32'(acc_en), 0);
        check({p, "_wren"}, 32'(wr_en), 0);
        check({p, "_addr"}, 32'(addr), 0);
        check({p, "_wdata"}, 32'(wdata), 0);
        check({p, "_r0"}, 32'(r0d), 0);
        check({p, "_r1"}, 32'(r1d), 0);
        check({p, "_err"}, 32'(err), 0);
    endtask

    task automatic do_reset();
        rq = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic hs(input int n, input logic w, input logic [2:0] a, input logic [15:0] d);
        bit got = 0;
        wr[n] = w; ad[n] = a; wd[n] = d; rq[n] = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = ack[n];
        end
        check("hs_ack", 32'(got), 1);
        rq[n] = 1'b0;
        @(negedge clk);
    endtask

    int          order [$];
    logic [1:0]  up;
    int          cnt_acc;
    bit          seen;
    int          done_n [2], gap [2], waited [2], accs [2];
    bit          busy [2];
    logic        ewr [2];
    logic [2:0]  ea [2];
    logic [15:0] ed [2], last_rd [2], mm [8];

    initial begin
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        @(negedge clk);

        // single write: latency and latched command
        rq = 2'b01; wr[0] = 1'b1; ad[0] = 3'd1; wd[0] = 16'h3155;
        @(negedge clk);
        check("w_acc", 32'(acc_en), 1);
        check("w_addr", 32'(addr), 1);
        check("w_wdata", 32'(wdata), 32'h3155);
        check("w_wren", 32'(wr_en), 1);
        check("w_gnt", 32'(gnt), 1);
        check("w_ack_early", 32'(ack), 0);
        ad[0] = 3'd7; wd[0] = 16'hffff; wr[0] = 1'b0;
        @(negedge clk);
        check("w_acc_off", 32'(acc_en), 0);
        check("w_ack", 32'(ack), 1);
        check("w_addr_off", 32'(addr), 0);
        check("w_wdata_off", 32'(wdata), 0);
        check("w_gnt_ack", 32'(gnt), 1);
        rq = 2'b00;
        @(negedge clk);
        check("w_ack_drop", 32'(ack), 0);
        check("w_gnt_drop", 32'(gnt), 0);

        // requester 1 reads back what requester 0 wrote
        hs(0, 1'b1, 3'd3, 16'h0203);
        rq = 2'b10; wr[1] = 1'b0; ad[1] = 3'd3;
        @(negedge clk);
        check("r_acc", 32'(acc_en), 1);
        check("r_addr", 32'(addr), 3);
        check("r_wren", 32'(wr_en), 0);
        @(negedge clk);
        check("r_ack", 32'(ack), 2);
        check("r_r1", 32'(r1d), 32'h0203);
        check("r_r0", 32'(r0d), 0);
        rq = 2'b00;
        @(negedge clk);

        // tie-breaking: both requesting back to back
        do_reset();
        wr = 2'b00; ad[0] = 3'd0; ad[1] = 3'd1; up = '0;
        rq = 2'b11;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (acc_en) order.push_back(int'(gnt[1]));
            for (int n = 0; n < 2; n++) begin
                if (ack[n]) begin rq[n] = 1'b0; up[n] = 1'b1; end
                else if (up[n]) begin rq[n] = 1'b1; up[n] = 1'b0; end
            end
        end
        check("rr_count", 32'(order.size()), 4);
        for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % 2));
        rq = 2'b00;
        repeat (4) @(negedge clk);

        // held req in ACK yields a single access
        rq = 2'b01; wr[0] = 1'b1; ad[0] = 3'd5; wd[0] = 16'h0011;
        cnt_acc = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (acc_en) cnt_acc++;
        end
`ifdef REG_ARB_ACK_TIMEOUT_EN
        check("hold_ack", 32'(ack), 0);
`else
        check("hold_ack", 32'(ack), 1);
`endif
        rq = 2'b00;
        repeat (3) begin
            @(negedge clk);
            if (acc_en) cnt_acc++;
        end
        check("hold_acc_once", 32'(cnt_acc), 1);

        // reset in the middle of ACCESS
        do_reset();
        rq = 2'b01; wr[0] = 1'b0; ad[0] = 3'd2;
        @(negedge clk);
        check("mid_acc", 32'(acc_en), 1);
        #2 rstn = 1'b0;
        #1 check_idle("midrst");
        rq = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= |ack;
        end
        check("midrst_no_ack", 32'(seen), 0);
        check("midrst_r0", 32'(r0d), 0);

`ifdef REG_ARB_ACK_TIMEOUT_EN
        // forced release after four ACK cycles
        do_reset();
        rq = 2'b01; wr[0] = 1'b1; ad[0] = 3'd5; wd[0] = 16'h0011;
        repeat (5) @(negedge clk);
        check("to_ack_last", 32'(ack), 1);
        check("to_err_early", 32'(err), 0);
        @(negedge clk);
        check("to_err", 32'(err), 1);
        check("to_ack_drop", 32'(ack), 0);
        check("to_gnt_drop", 32'(gnt), 0);
        @(negedge clk);
        check("to_err_pulse", 32'(err), 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= acc_en;
        end
        check("to_no_reserve", 32'(seen), 0);
        rq = 2'b00;
        @(negedge clk);
        rq = 2'b01;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= acc_en;
        end
        check("to_reserve", 32'(seen), 1);
        rq = 2'b00;
        repeat (8) @(negedge clk);
`endif

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 8; i++) mm[i] = '0;
        for (int n = 0; n < 2; n++) begin
            done_n[n] = 0; gap[n] = n; busy[n] = 0; last_rd[n] = '0;
        end
        for (int c = 0; c < 4000 && (done_n[0] < NTX || done_n[1] < NTX || busy[0] || busy[1]); c++) begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            for (int n = 0; n < 2; n++) begin
                if (busy[n]) begin
                    waited[n]++;
                    if (acc_en && gnt[n]) begin
                        accs[n]++;
                        check("rnd_addr", 32'(addr), 32'(ea[n]));
                        check("rnd_wdata", 32'(wdata), 32'(ed[n]));
                        check("rnd_wren", 32'(wr_en), 32'(ewr[n]));
                    end
                    if (gnt[n]) begin
                        wr[n] = 1'($urandom_range(0, 1));
                        ad[n] = 3'($urandom_range(0, 7));
                        wd[n] = 16'($urandom);
                    end
                    if (ack[n]) begin
                        check("rnd_one_access", 32'(accs[n]), 1);
                        if (ewr[n]) mm[ea[n]] = ed[n];
                        else last_rd[n] = mm[ea[n]];
                        check("rnd_rdata", 32'(n == 1 ? r1d : r0d), 32'(last_rd[n]));
                        check("rnd_other_rdata", 32'(n == 1 ? r0d : r1d), 32'(last_rd[1-n]));
                        rq[n] = 1'b0; busy[n] = 0; done_n[n]++;
                        gap[n] = int'($urandom_range(0, 3));
                    end else if (waited[n] > 30) begin
                        check("rnd_ack_within_bound", 0, 1);
                        rq[n] = 1'b0; busy[n] = 0; done_n[n]++;
                    end
                end else if (gap[n] > 0) begin
                    gap[n]--;
                end else if (done_n[n] < NTX) begin
                    ewr[n] = 1'($urandom_range(0, 1));
                    ea[n] = 3'($urandom_range(0, 7));
                    ed[n] = 16'($urandom);
                    wr[n] = ewr[n]; ad[n] = ea[n]; wd[n] = ed[n];
                    rq[n] = 1'b1; busy[n] = 1; waited[n] = 0; accs[n] = 0;
                end
            end
        end
        check("rnd_done0", 32'(done_n[0]), NTX);
        check("rnd_done1", 32'(done_n[1]), NTX);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
